// File: rtl/vga_timing_pkg.sv
`default_nettype none
// vga_timing_pkg: 640x480@60 timing shared with the sync generator, decoder
// FSM encoding and the position-counter helper.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_H_TOTAL        = 800;
  localparam int VGA_V_TOTAL        = 525;
  localparam int VGA_H_VISIBLE_AREA = 640;
  localparam int VGA_H_SYNC_PULSE   = 96;
  localparam int VGA_V_VISIBLE_AREA = 480;
  localparam int VGA_V_SYNC_PULSE   = 2;
  localparam int VGA_LOCK_LINES     = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    H_ACQ  = 2'd1,
    V_ACQ  = 2'd2,
    LOCKED = 2'd3
  } sync_state_e;

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] val,
                                                input int               limit);
    return (val == CNT_W'(limit - 1)) ? '0 : val + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// sync_edge_detect: one-deep input register; rise/fall compare the live input
// with the previously registered sample.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// vga_sync_decoder: recovers pixel position, visibility and lock status from
// incoming HSync/VSync pulses and flags any deviation from the configured mode.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL        = VGA_H_TOTAL,
  parameter int V_TOTAL        = VGA_V_TOTAL,
  parameter int H_VISIBLE_AREA = VGA_H_VISIBLE_AREA,
  parameter int H_SYNC_PULSE   = VGA_H_SYNC_PULSE,
  parameter int V_VISIBLE_AREA = VGA_V_VISIBLE_AREA,
  parameter int V_SYNC_PULSE   = VGA_V_SYNC_PULSE,
  parameter int LOCK_LINES     = VGA_LOCK_LINES
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_HSync,
  input  logic             i_VSync,
  output logic [CNT_W-1:0] o_H_Counter,
  output logic [CNT_W-1:0] o_V_Counter,
  output logic             o_Visible,
  output logic             o_Locked,
  output logic             o_Frame_Start,
  output logic             o_Sync_Err,
  output logic [7:0]       o_Err_Count
);

  localparam int WD_W   = 11;
  localparam int GOOD_W = $clog2(LOCK_LINES + 1);

  localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]  H_RISE    = CNT_W'(H_VISIBLE_AREA);
  localparam logic [CNT_W-1:0]  H_FALL    = CNT_W'(H_VISIBLE_AREA + H_SYNC_PULSE);
  localparam logic [CNT_W-1:0]  V_RISE    = CNT_W'(V_VISIBLE_AREA);
  localparam logic [CNT_W-1:0]  V_FALL    = CNT_W'(V_VISIBLE_AREA + V_SYNC_PULSE);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(2 * H_TOTAL - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_LINES - 1);

  sync_state_e       state, state_nxt;
  logic [CNT_W-1:0]  h_cnt, v_cnt, h_nxt, v_nxt, h_inc, v_inc;
  logic [WD_W-1:0]   wd_cnt, wd_nxt;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic [7:0]        err_count;
  logic              sync_err, err_nxt;
  logic              hs_rise, hs_fall, vs_rise, vs_fall;
  logic              wd_expired, hs_bad_rise, locked_err, locked;

  sync_edge_detect u_hs_edge (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .sig   (i_HSync),
    .rise  (hs_rise),
    .fall  (hs_fall)
  );

  sync_edge_detect u_vs_edge (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .sig   (i_VSync),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  // All checks use the position this cycle's sample belongs to: the free-running next count.
  always_comb begin
    h_inc       = wrap_inc(h_cnt, H_TOTAL);
    v_inc       = (h_cnt == H_LAST) ? wrap_inc(v_cnt, V_TOTAL) : v_cnt;
    wd_expired  = (state != HUNT) && !hs_rise && (wd_cnt == WD_LAST);
    hs_bad_rise = hs_rise && (h_inc != H_RISE);
    locked_err  = hs_bad_rise
               || (hs_fall && (h_inc != H_FALL))
               || (i_HSync && !hs_rise && (h_inc == H_RISE))
               || (vs_rise && !((h_inc == '0) && (v_inc == V_RISE)))
               || (vs_fall && !((h_inc == '0) && (v_inc == V_FALL)))
               || (i_VSync && (h_inc == '0) && (v_inc == V_FALL));
  end

  always_comb begin
    state_nxt = state;
    h_nxt     = h_inc;
    v_nxt     = v_inc;
    good_nxt  = good_cnt;
    err_nxt   = 1'b0;
    wd_nxt    = hs_rise ? '0 : wd_cnt + 1'b1;
    if (wd_expired) begin
      state_nxt = HUNT;
      h_nxt     = '0;
      v_nxt     = '0;
      good_nxt  = '0;
      wd_nxt    = '0;
      err_nxt   = 1'b1;
    end else begin
      case (state)
        HUNT: begin
          h_nxt    = '0;
          v_nxt    = '0;
          wd_nxt   = '0;
          good_nxt = '0;
          if (hs_rise) begin
            state_nxt = H_ACQ;
            h_nxt     = H_RISE;
          end
        end
        H_ACQ: begin
          if (hs_bad_rise) begin
            h_nxt    = H_RISE;
            good_nxt = '0;
            err_nxt  = 1'b1;
          end else if (hs_rise) begin
            good_nxt = good_cnt + 1'b1;
            if (good_cnt == GOOD_LAST) state_nxt = V_ACQ;
          end
        end
        V_ACQ: begin
          if (hs_bad_rise) begin
            state_nxt = H_ACQ;
            h_nxt     = H_RISE;
            good_nxt  = '0;
            err_nxt   = 1'b1;
          end else if (vs_rise) begin
            if (h_inc == '0) begin
              v_nxt     = V_RISE;
              state_nxt = LOCKED;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        default: begin
          if (locked_err) begin
            state_nxt = H_ACQ;
            good_nxt  = '0;
            err_nxt   = 1'b1;
            if (hs_rise) h_nxt = H_RISE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= HUNT;
      h_cnt     <= '0;
      v_cnt     <= '0;
      wd_cnt    <= '0;
      good_cnt  <= '0;
      sync_err  <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      h_cnt     <= h_nxt;
      v_cnt     <= v_nxt;
      wd_cnt    <= wd_nxt;
      good_cnt  <= good_nxt;
      sync_err  <= err_nxt;
      if (err_nxt && (err_count != 8'hFF)) err_count <= err_count + 1'b1;
    end
  end

  assign locked        = (state == LOCKED);
  assign o_H_Counter   = h_cnt;
  assign o_V_Counter   = v_cnt;
  assign o_Locked      = locked;
  assign o_Visible     = locked && (h_cnt < H_RISE) && (v_cnt < V_RISE);
  assign o_Frame_Start = locked && (h_cnt == '0) && (v_cnt == '0);
  assign o_Sync_Err    = sync_err;
  assign o_Err_Count   = err_count;

endmodule
`default_nettype wire
